shamt_seq_shifter: RTL
======================

# shamt_seq_shifter

Multi-cycle shift unit that consumes the 32-bit zero-extended shift amount produced by the shamt zero-extension stage, together with the rt operand, and performs SLL/SRL/SRA one bit position per clock. It sits on the execute path beside the ALU for shift-class R-type instructions and reports completion with a start/done handshake, so the control path stalls for the duration of the shift.

## Interface
- No parameters. Data width is fixed at 32; shift counter width is fixed at 5.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a shift; sampled only in IDLE
- op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = pass-through (no shift)
- operand  input  32  value to shift (rt)
- shamt_ext  input  32  zero-extended shift amount; only bits [4:0] used, [31:5] ignored
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse; result valid in that cycle
- result  output  32  shifted value; holds until the next accepted start

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, capture operand into the data register, op into the op register, and shamt_ext[4:0] into the counter.
  - Next state is DONE if the count is 0 or op=11. Otherwise next state is SHIFT.
- SHIFT: each cycle, shift the data register by one position and decrement the counter. When the counter reaches 1, this is the last shift and the next state is DONE.
  - SLL: shift left, 0 into bit 0.
  - SRL: shift right, 0 into bit 31.
  - SRA: shift right, old bit 31 into bit 31.
- DONE: assert done=1 for exactly one cycle, then return to IDLE. Do not accept start in this cycle.
- result is driven directly from the data register. It changes during SHIFT and is stable from DONE until the next accepted start.
- start while busy=1 is ignored. No queuing, no error flag.
- op, operand and shamt_ext are only sampled on an accepted start. Changes on these inputs at any other time have no effect.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0.
- Reset mid-operation aborts the shift immediately at the next edge. No done pulse is issued for the aborted shift.

## Timing
- An accepted start at edge N gives done=1 in the cycle after edge N+k, where k = shamt_ext[4:0], or k = 0 when op=11.
  - Total latency is k+1 cycles.
  - Shortest case: 1 cycle (shamt 0 or op 11).
  - Longest case: 32 cycles (shamt 31).
- busy rises in the cycle after the accepted start and falls together with done at the transition back to IDLE.
- A new start is accepted no earlier than the first IDLE cycle after done, giving a back-to-back throughput of one shift per k+2 cycles.
- When reset and start are high in the same cycle, reset wins.

## Structure
- Shared package holds:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_PASS=2'b11;
  - state encodings: IDLE, SHIFT, DONE as 2-bit constants;
  - DATA_W=32 and SHAMT_W=5.
- One sub-module, shift1_unit: a purely combinational single-position shifter (op, in[31:0] → out[31:0]), instantiated once in the datapath.
- The top level holds the FSM, the 5-bit down-counter, and the data and op registers.

## Test plan
- SLL: operand=0x0000_0001, shamt_ext=0x0000_0004, op=00 → done 5 cycles after start, result=0x0000_0010, busy high for 5 cycles.
- SRA: operand=0x8000_0000, shamt_ext=31 → result=0xFFFF_FFFF, done at cycle 32. SRL with the same inputs → result=0x0000_0001.
- Zero and pass-through: shamt_ext=0 with op=00 → done in 1 cycle, result=operand. op=11 with shamt_ext=7 → done in 1 cycle, result=operand.
- Upper-bit masking: shamt_ext=0xFFFF_FFE2, op=01, operand=0x0000_0100 → effective shift 2, result=0x0000_0040.
- Start while busy: a second start with a different operand during SHIFT is ignored. The first result completes unchanged and a single done pulse is issued.
- Reset mid-shift: assert reset 3 cycles into a 10-bit shift → next cycle state IDLE, busy=0, done=0, result=0. A subsequent start completes normally.

Source files
------------

// File: rtl/shamt_seq_shifter_pkg.sv
// Shared constants and types for the bit-serial shamt shifter.
// Op and state encodings are fixed 2-bit values used by the RTL and the bench.
package shamt_seq_shifter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Zero shift or pass-through skips the SHIFT state entirely.
    function automatic logic is_single_cycle(input logic [1:0] op,
                                             input logic [SHAMT_W-1:0] shamt);
        return (shamt == '0) || (op == OP_PASS);
    endfunction

endpackage

// File: rtl/shamt_seq_shifter_if.sv
// Start/done handshake and operand bus between the execute control path and the shifter.
// The master drives the request side; the shifter is the slave.
interface shamt_seq_shifter_if;
    import shamt_seq_shifter_pkg::*;

    logic              i_start;
    logic [1:0]        i_op;
    logic [DATA_W-1:0] i_operand;
    logic [DATA_W-1:0] i_shamt_ext;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_result;

    modport master (
        output i_start, i_op, i_operand, i_shamt_ext,
        input  o_busy, o_done, o_result
    );

    modport slave (
        input  i_start, i_op, i_operand, i_shamt_ext,
        output o_busy, o_done, o_result
    );

endinterface

// File: rtl/shamt_seq_shifter_shift1_unit.sv
// Combinational single-position shifter: one step of SLL/SRL/SRA, pass-through otherwise.
module shift1_unit
    import shamt_seq_shifter_pkg::*;
(
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL:  o_data = {i_data[DATA_W-2:0], 1'b0};
            OP_SRL:  o_data = {1'b0, i_data[DATA_W-1:1]};
            OP_SRA:  o_data = {i_data[DATA_W-1], i_data[DATA_W-1:1]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/shamt_seq_shifter.sv
// Multi-cycle shift unit: one bit position per clock, start/done handshake.
// Latency is shamt[4:0]+1 cycles (1 cycle for zero shift or pass-through).
module shamt_seq_shifter
    import shamt_seq_shifter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    shamt_seq_shifter_if.slave bus
);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [DATA_W-1:0]         r_data;
    logic [1:0]                r_op;
    logic [SHAMT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]         w_shifted;
    logic [SHAMT_W-1:0]        w_shamt;
    logic                      w_accept;
    logic                      w_busy;
    logic                      w_done;
    logic [DATA_W-SHAMT_W-1:0] w_unused_shamt_hi;

    assign w_shamt           = bus.i_shamt_ext[SHAMT_W-1:0];
    assign w_unused_shamt_hi = bus.i_shamt_ext[DATA_W-1:SHAMT_W];
    assign w_accept          = (r_state == IDLE) && bus.i_start;

    shift1_unit u_shift1 (
        .i_op   (r_op),
        .i_data (r_data),
        .o_data (w_shifted)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = is_single_cycle(bus.i_op, w_shamt) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (r_cnt == SHAMT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Data/op/count only load on an accepted start, so result holds through IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
            r_op   <= OP_SLL;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_data <= bus.i_operand;
            r_op   <= bus.i_op;
            r_cnt  <= w_shamt;
        end else if (r_state == SHIFT) begin
            r_data <= w_shifted;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end

    assign bus.o_busy   = w_busy;
    assign bus.o_done   = w_done;
    assign bus.o_result = r_data;

endmodule
